// File: rtl/mem_access_unit.sv
// mem_access_unit: drives the data-memory port for load/store requests.
// Stores are lane-aligned. Loads are shifted down to bit 0 for the register
// file. Accesses that straddle a word boundary become two aligned word accesses.
// Optional build macro MISALIGN_TRAP_EN: straddling requests are refused
// (no memory access) and complete with misalign_err instead of being split.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic [31:0] daddr,
  output logic        dre,
  output logic [3:0]  dwe,
  output logic [31:0] dwdata,
  input  logic [31:0] drdata,
  output logic [3:0]  rf_we,
  output logic [31:0] rf_wdata,
  output logic [4:0]  rf_rd,
  output logic        l_unsign_flag,
  output logic        done,
  output logic        misalign_err
);

  typedef enum logic [2:0] {IDLE, ACC0, ACC1, CAPT, RESP} state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Size code 3 behaves as a word everywhere, so it is folded at latch time.
  function automatic logic [1:0] norm_size(input logic [1:0] s);
    return (s == 2'd3) ? SZ_W : s;
  endfunction

  function automatic logic needs_split(input logic [1:0] s, input logic [1:0] off);
    case (s)
      SZ_H:    return (off == 2'd3);
      SZ_W:    return (off != 2'd0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask0(input logic [1:0] s, input logic [1:0] off);
    case (s)
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return 4'b0011 << off;
      default: return 4'b1111 << off;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask1(input logic [1:0] s, input logic [1:0] off);
    case (s)
      SZ_H:    return 4'b0001;
      SZ_W:    return 4'b1111 >> (3'd4 - {1'b0, off});
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] we_code(input logic [1:0] s);
    case (s)
      SZ_B:    return 4'b0001;
      SZ_H:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] size_mask(input logic [1:0] s);
    case (s)
      SZ_B:    return 32'h0000_00FF;
      SZ_H:    return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [31:0] addr_q, wdata_q, buf0_q, rfdata_q;
  logic [1:0]  size_q;
  logic        store_q, unsign_q, err_q;
  logic [4:0]  rd_q;

  logic        accept, trap_now, split;
  logic [1:0]  off;
  logic [4:0]  sh;
  logic [31:0] a0, a1;
  logic [63:0] ld_win;
  logic [31:0] ld_data;

`ifdef MISALIGN_TRAP_EN
  assign trap_now = needs_split(norm_size(req_size), req_addr[1:0]);
`else
  assign trap_now = 1'b0;
`endif

  assign accept = req_valid && req_ready;
  assign off    = addr_q[1:0];
  assign sh     = {off, 3'b000};
  assign a0     = {addr_q[31:2], 2'b00};
  assign a1     = a0 + 32'd4;
  assign split  = needs_split(size_q, off);

  // Load alignment: the upper word of a split load is taken straight from
  // drdata in CAPT, so only the lower word needs a holding register.
  always_comb begin
    ld_win  = split ? {drdata, buf0_q} : {32'd0, drdata};
    ld_win  = ld_win >> sh;
    ld_data = ld_win[31:0] & size_mask(size_q);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Request latch, read-data buffer and load result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      store_q  <= 1'b0;
      unsign_q <= 1'b0;
      rd_q     <= '0;
      err_q    <= 1'b0;
      buf0_q   <= '0;
      rfdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        size_q   <= norm_size(req_size);
        store_q  <= req_store;
        unsign_q <= req_unsign;
        rd_q     <= req_rd;
        err_q    <= trap_now;
      end
      if (state_q == ACC1 && !store_q) buf0_q <= drdata;
      if (state_q == CAPT) begin
        if (!split) buf0_q <= drdata;
        rfdata_q <= ld_data;
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    daddr         = '0;
    dre           = 1'b0;
    dwe           = 4'b0000;
    dwdata        = '0;
    rf_we         = 4'b0000;
    rf_wdata      = '0;
    rf_rd         = '0;
    l_unsign_flag = 1'b0;
    done          = 1'b0;
    misalign_err  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = trap_now ? RESP : ACC0;
      end
      ACC0: begin
        daddr = a0;
        if (store_q) begin
          dwe    = lane_mask0(size_q, off);
          dwdata = wdata_q << sh;
        end else begin
          dre = 1'b1;
        end
        if (split)        state_d = ACC1;
        else if (store_q) state_d = RESP;
        else              state_d = CAPT;
      end
      ACC1: begin
        daddr = a1;
        if (store_q) begin
          dwe    = lane_mask1(size_q, off);
          dwdata = wdata_q >> (6'd32 - {1'b0, sh});
        end else begin
          dre = 1'b1;
        end
        state_d = store_q ? RESP : CAPT;
      end
      CAPT: state_d = RESP;
      RESP: begin
        done         = 1'b1;
        misalign_err = err_q;
        if (!store_q && !err_q) begin
          rf_wdata      = rfdata_q;
          rf_rd         = rd_q;
          l_unsign_flag = unsign_q;
          if (rd_q != 5'd0) rf_we = we_code(size_q);
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
